l2_cacheline_adapter: RTL

// Memory-side responder for the L2 cache's 256-bit line interface (pmem_*). Accepts one

---
 rtl/l2_adapter_pkg.sv | 19 +
 rtl/l2_cacheline_adapter.sv | 106 ++++++++++
 2 files changed

// File: rtl/l2_adapter_pkg.sv
// Shared constants and state encoding for the L2 line <-> memory burst adapter.
// A 256-bit cache line is carried as a 4 x 64-bit burst.
package l2_adapter_pkg;

    localparam int BEATS    = 4;
    localparam int BEAT_W   = 64;
    localparam int LINE_W   = BEAT_W * BEATS;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        RELEASE
    } adapter_state_e;

endpackage

// File: rtl/l2_cacheline_adapter.sv
// Memory-side responder for the L2 line port: one line read/write becomes a
// 4-beat burst to physical memory, answered by a single-cycle line_resp.
module l2_cacheline_adapter
    import l2_adapter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   line_address,
    input  logic [LINE_W-1:0]   line_wdata,
    input  logic                line_read,
    input  logic                line_write,
    output logic [LINE_W-1:0]   line_rdata,
    output logic                line_resp,
    output logic [ADDR_W-1:0]   burst_address,
    output logic [BEAT_W-1:0]   burst_wdata,
    input  logic [BEAT_W-1:0]   burst_rdata,
    output logic                burst_read,
    output logic                burst_write,
    input  logic                burst_resp
);

    adapter_state_e    r_state;
    adapter_state_e    w_state_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [LINE_W-1:0] r_wline;
    logic              w_beat_go;
    logic              w_last_beat;
    logic              w_accept;
    logic              w_unused_offset;

    // The line offset bits never reach memory; bursts are always line-aligned.
    assign w_unused_offset = ^line_address[OFFSET_W-1:0];

    assign w_beat_go   = burst_resp && (r_state == RD || r_state == WR);
    assign w_last_beat = w_beat_go && (r_beat_cnt == CNT_W'(BEATS - 1));
    assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);
    assign w_accept    = (r_state == IDLE) && (line_read || line_write);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (line_write)
                    w_state_nxt = WR;
                else if (line_read)
                    w_state_nxt = RD;
            end
            RD, WR: begin
                if (w_last_beat)
                    w_state_nxt = DONE;
            end
            DONE: w_state_nxt = RELEASE;
            // Hold here until the L2 drops its request so it is not taken twice.
            RELEASE: begin
                if (!line_read && !line_write)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Outputs are registered from the next state so they are Moore and glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt    <= '0;
            r_wline       <= '0;
            line_rdata    <= '0;
            line_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= '0;
            burst_wdata   <= '0;
        end else begin
            burst_read  <= (w_state_nxt == RD);
            burst_write <= (w_state_nxt == WR);
            line_resp   <= (w_state_nxt == DONE);

            if (w_accept)
                burst_address <= {line_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

            if (r_state == IDLE && line_write) begin
                r_wline     <= line_wdata;
                burst_wdata <= line_wdata[BEAT_W-1:0];
            end

            if (w_beat_go) begin
                r_beat_cnt <= w_cnt_inc;
                if (r_state == RD)
                    line_rdata[int'(r_beat_cnt)*BEAT_W +: BEAT_W] <= burst_rdata;
                if (r_state == WR && !w_last_beat)
                    burst_wdata <= r_wline[int'(w_cnt_inc)*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule
